// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: a - b - borrow_in, DIGIT bits per clock through a
// chain of full-subtractor cells, with valid/ready handshakes and a mode-dependent overflow.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic             smode_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] slice;
    logic             chain_b;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    // Ripple the current DIGIT-bit slice through the cell chain.
    always_comb begin
        slice   = '0;
        chain_b = borrow_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            slice[i] = a_q[i] ^ b_q[i] ^ chain_b;
            chain_b  = (~a_q[i] & b_q[i]) | (~a_q[i] & chain_b) | (b_q[i] & chain_b);
        end
        res_next = (res_q >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));
        // Operand MSBs are kept aside because a_q/b_q are shifted away during BUSY.
        ovf_next = smode_q ? ((a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q))
                           : chain_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            smode_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= borrow_in;
                        smode_q  <= signed_mode;
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    borrow_q <= chain_b;
                    res_q    <= res_next;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(STEPS - 1)) begin
                        diff_q  <= res_next;
                        bout_q  <= chain_b;
                        ovf_q   <= ovf_next;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;

endmodule
